// File: rtl/skeleton_pass_sequencer_pkg.sv
// Shared types and sizes for the skeleton pass sequencer slice.
package skel_pkg;
  localparam int N           = 8;
  localparam int BIT_SIZE    = 6;
  localparam int PIXEL_WIDTH = 8;
  localparam int PASS_W      = 4;
  localparam int NPIX        = N * N;
  localparam int SLOT_CYCLES = 2;
  localparam int ADDR_W      = BIT_SIZE + 1;

  typedef logic [ADDR_W-1:0]      addr_t;
  typedef logic [PIXEL_WIDTH-1:0] pix_t;
  typedef logic [PASS_W-1:0]      pass_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LOAD_FLUSH,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } seq_state_t;

  localparam addr_t LAST_ADDR = addr_t'(NPIX - 1);
endpackage

// File: rtl/skeleton_pass_sequencer_if.sv
// Image RAM port and kernel-unit bus seen by the pass sequencer.
interface skeleton_pass_sequencer_if;
  import skel_pkg::*;

  addr_t mem_addr;
  logic  mem_rd_en;
  pix_t  mem_rd_data;
  logic  mem_wr_en;
  pix_t  mem_wr_data;
  logic  k_we;
  addr_t k_addr;
  pix_t  k_data;
  pix_t  k_result;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, k_we, k_addr, k_data,
    input  mem_rd_data, k_result
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, k_we, k_addr, k_data,
    output mem_rd_data, k_result
  );
endinterface

// File: rtl/skeleton_pass_sequencer_slot_timer.sv
// Two-cycle slot toggle plus saturating pixel address counter.
module skel_slot_timer
  import skel_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  clear,
  input  logic  advance,
  output logic  slot_phase,
  output addr_t addr,
  output logic  last_addr
);
  logic  phase_q, phase_d;
  addr_t addr_q, addr_d;

  always_comb begin
    phase_d = phase_q;
    addr_d  = addr_q;
    if (clear) begin
      phase_d = 1'b0;
      addr_d  = '0;
    end else if (advance) begin
      phase_d = ~phase_q;
      // address steps at the end of a slot and parks on the last pixel
      if (phase_q == 1'(SLOT_CYCLES - 1) && addr_q != LAST_ADDR)
        addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      phase_q <= phase_d;
      addr_q  <= addr_d;
    end
  end

  assign slot_phase = phase_q;
  assign addr       = addr_q;
  assign last_addr  = (addr_q == LAST_ADDR);
endmodule

// File: rtl/skeleton_pass_sequencer.sv
// Runs LOAD/DRAIN thinning passes over the image RAM until a pass changes
// nothing or the pass limit is reached.
module skeleton_pass_sequencer
  import skel_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  input  pass_t max_passes,
  output logic  busy,
  output logic  done,
  output logic  converged,
  output pass_t pass_count,
  skeleton_pass_sequencer_if.master bus
);
  seq_state_t state_q, state_d;
  pass_t      max_q, max_d;
  pass_t      pass_q, pass_d;
  logic       chg_q, chg_d;
  logic       conv_q, conv_d;
  logic       k_we_q, k_we_d;
  addr_t      k_addr_q, k_addr_d;
  pix_t       k_data_q, k_data_d;

  logic  tmr_clear, tmr_adv, slot_phase, last_addr;
  addr_t cur_addr;
  addr_t mem_addr;
  logic  rd_en, wr_en;
  pix_t  wr_data;
  pass_t lim;
  logic [PASS_W:0] next_pc;

  skel_slot_timer u_timer (
    .clk(clk), .rst_n(rst_n), .clear(tmr_clear), .advance(tmr_adv),
    .slot_phase(slot_phase), .addr(cur_addr), .last_addr(last_addr)
  );

  assign lim     = (max_q == '0) ? pass_t'(1) : max_q;
  assign next_pc = {1'b0, pass_q} + 1'b1;

  always_comb begin
    state_d   = state_q;
    max_d     = max_q;
    pass_d    = pass_q;
    chg_d     = chg_q;
    conv_d    = conv_q;
    k_we_d    = k_we_q;
    k_addr_d  = k_addr_q;
    k_data_d  = k_data_q;
    tmr_clear = 1'b0;
    tmr_adv   = 1'b0;
    mem_addr  = '0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          pass_d    = '0;
          max_d     = max_passes;
          chg_d     = 1'b0;
          conv_d    = 1'b0;
          tmr_clear = 1'b1;
        end
      end
      S_LOAD: begin
        tmr_adv = 1'b1;
        if (!slot_phase) begin
          rd_en    = 1'b1;
          mem_addr = cur_addr;
        end else begin
          // read data from cycle 0 is captured onto the bus for the next slot
          k_we_d   = 1'b1;
          k_addr_d = cur_addr;
          k_data_d = bus.mem_rd_data;
          if (last_addr) begin
            state_d   = S_LOAD_FLUSH;
            tmr_clear = 1'b1;
          end
        end
      end
      S_LOAD_FLUSH: begin
        tmr_adv = 1'b1;
        if (slot_phase) begin
          k_we_d    = 1'b0;
          k_addr_d  = '0;
          k_data_d  = '0;
          state_d   = S_DRAIN;
          tmr_clear = 1'b1;
        end
      end
      S_DRAIN: begin
        tmr_adv  = 1'b1;
        mem_addr = cur_addr;
        if (!slot_phase) begin
          rd_en = 1'b1;
        end else begin
          if (bus.k_result != bus.mem_rd_data) begin
            wr_en   = 1'b1;
            wr_data = bus.k_result;
            chg_d   = 1'b1;
          end
          if (last_addr) begin
            state_d   = S_CHECK;
            k_addr_d  = '0;
            tmr_clear = 1'b1;
          end else begin
            k_addr_d = cur_addr + 1'b1;
          end
        end
      end
      S_CHECK: begin
        pass_d = next_pc[PASS_W-1:0];
        if (!chg_q) begin
          conv_d  = 1'b1;
          state_d = S_DONE;
        end else if (next_pc >= {1'b0, lim}) begin
          conv_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          chg_d     = 1'b0;
          state_d   = S_LOAD;
          tmr_clear = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      max_q    <= '0;
      pass_q   <= '0;
      chg_q    <= 1'b0;
      conv_q   <= 1'b0;
      k_we_q   <= 1'b0;
      k_addr_q <= '0;
      k_data_q <= '0;
    end else begin
      state_q  <= state_d;
      max_q    <= max_d;
      pass_q   <= pass_d;
      chg_q    <= chg_d;
      conv_q   <= conv_d;
      k_we_q   <= k_we_d;
      k_addr_q <= k_addr_d;
      k_data_q <= k_data_d;
    end
  end

  assign busy            = (state_q != S_IDLE);
  assign done            = (state_q == S_DONE);
  assign converged       = conv_q;
  assign pass_count      = pass_q;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wr_data = wr_data;
  assign bus.k_we        = k_we_q;
  assign bus.k_addr      = k_addr_q;
  assign bus.k_data      = k_data_q;
endmodule

// File: tb/tb_skeleton_pass_sequencer.sv
// Directed vector bench: RAM and kernel models around the pass sequencer.
module tb_skeleton_pass_sequencer;
  import skel_pkg::*;

  logic  clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  pass_t max_passes = '0;
  logic  busy, done, converged;
  pass_t pass_count;

  skeleton_pass_sequencer_if bus();

  skeleton_pass_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .max_passes(max_passes),
    .busy(busy), .done(done), .converged(converged), .pass_count(pass_count),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int mode = 0, tb_pass = 0;
  pix_t ram  [2**ADDR_W];
  pix_t kimg [2**ADDR_W];
  pix_t rd_q = '0;

  // kernel models: 0 identity, 1 zero pixel 27 in pass 1, 2 invert pixel 0
  function automatic pix_t kmodel(int m, int p, addr_t a, pix_t v);
    if (m == 1 && p == 1 && a == 7'd27) return '0;
    if (m == 2 && a == 7'd0) return ~v;
    return v;
  endfunction

  assign bus.mem_rd_data = rd_q;
  assign bus.k_result    = kmodel(mode, tb_pass, bus.k_addr, kimg[bus.k_addr]);

  always @(posedge clk) begin
    if (bus.mem_rd_en) rd_q <= ram[bus.mem_addr];
    if (bus.mem_wr_en) ram[bus.mem_addr] <= bus.mem_wr_data;
    if (bus.k_we) kimg[bus.k_addr] <= bus.k_data;
  end

  task automatic chk(string nm, int act, int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // bus monitor
  logic  mon_en = 1'b0, kwe_prev = 1'b0, overlap = 1'b0;
  addr_t prev_a = '0;
  pix_t  prev_d = '0;
  int rd_cnt = 0, wr_cnt = 0, words = 0, word_idx = 0, run_len = 0;
  int last_wa = 0, last_wd = 0;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.mem_rd_en && bus.mem_wr_en) overlap = 1'b1;
      if (bus.mem_rd_en) rd_cnt++;
      if (bus.mem_wr_en) begin
        wr_cnt++;
        last_wa = int'(bus.mem_addr);
        last_wd = int'(bus.mem_wr_data);
      end
      if (bus.k_we) begin
        if (kwe_prev && bus.k_addr == prev_a && bus.k_data == prev_d) begin
          run_len++;
        end else begin
          if (kwe_prev) chk("k_hold", run_len, SLOT_CYCLES);
          chk("k_addr_seq", int'(bus.k_addr), word_idx);
          chk("k_data_ram", int'(bus.k_data), int'(ram[bus.k_addr]));
          word_idx++;
          words++;
          run_len = 1;
        end
      end else if (kwe_prev) begin
        chk("k_hold_last", run_len, SLOT_CYCLES);
        chk("load_words", word_idx, NPIX);
        word_idx = 0;
        tb_pass++;
      end
      kwe_prev = bus.k_we;
      prev_a   = bus.k_addr;
      prev_d   = bus.k_data;
    end
  end

  typedef struct {
    int mode; int maxp; bit uni; int conv; int pc; int wr; int wa; int wd;
  } vec_t;
  vec_t vecs [6];

  task automatic setup(int m, bit uni);
    for (int i = 0; i < NPIX; i++) ram[i] <= uni ? 8'h40 : pix_t'(i * 3 + 1);
    mode = m; tb_pass = 0;
    rd_cnt = 0; wr_cnt = 0; words = 0; word_idx = 0; run_len = 0;
    overlap = 1'b0; kwe_prev = 1'b0; last_wa = -1; last_wd = -1;
    mon_en = 1'b1;
  endtask

  task automatic do_start(int m);
    max_passes = pass_t'(m);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("pc_after_start", int'(pass_count), 0);
  endtask

  task automatic wait_done();
    int cyc = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", int'(done), 1);
  endtask

  task automatic run_vec(int i);
    setup(vecs[i].mode, vecs[i].uni);
    do_start(vecs[i].maxp);
    wait_done();
    chk("converged", int'(converged), vecs[i].conv);
    chk("pass_count", int'(pass_count), vecs[i].pc);
    chk("writes", wr_cnt, vecs[i].wr);
    chk("reads", rd_cnt, 2 * NPIX * vecs[i].pc);
    chk("kbus_words", words, NPIX * vecs[i].pc);
    chk("rd_wr_overlap", int'(overlap), 0);
    if (vecs[i].wr > 0) begin
      chk("last_wr_addr", last_wa, vecs[i].wa);
      chk("last_wr_data", last_wd, vecs[i].wd);
    end
    @(negedge clk);
    chk("done_pulse", int'(done), 0);
    chk("busy_idle", int'(busy), 0);
    chk("pc_hold", int'(pass_count), vecs[i].pc);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{0, 4, 1'b1, 1, 1, 0, 0, 0};
    vecs[1] = '{1, 4, 1'b0, 1, 2, 1, 27, 0};
    vecs[2] = '{2, 3, 1'b0, 0, 3, 3, 0, 8'hFE};
    vecs[3] = '{2, 0, 1'b0, 0, 1, 1, 0, 8'hFE};
    vecs[4] = '{0, 0, 1'b1, 1, 1, 0, 0, 0};
    vecs[5] = '{1, 1, 1'b0, 0, 1, 1, 27, 0};

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_conv", int'(converged), 0);
    chk("rst_pc", int'(pass_count), 0);
    chk("rst_rd_en", int'(bus.mem_rd_en), 0);
    chk("rst_k_we", int'(bus.k_we), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i);

    // start pulse during DRAIN of pass 1 must be ignored
    setup(1, 1'b0);
    do_start(4);
    cyc = 0;
    while (tb_pass == 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("reached_drain", tb_pass, 1);
    repeat (10) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("mid_start_pc", int'(pass_count), 2);
    chk("mid_start_conv", int'(converged), 1);
    chk("mid_start_wr", wr_cnt, 1);

    // back-to-back: start in the IDLE cycle straight after done
    @(negedge clk);
    chk("b2b_idle", int'(busy), 0);
    setup(0, 1'b1);
    do_start(4);
    wait_done();
    chk("b2b_pc", int'(pass_count), 1);
    chk("b2b_conv", int'(converged), 1);

    // asynchronous reset in the middle of LOAD
    @(negedge clk);
    setup(2, 1'b0);
    do_start(3);
    repeat (20) @(negedge clk);
    chk("pre_rst_k_we", int'(bus.k_we), 1);
    mon_en = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_k_we", int'(bus.k_we), 0);
    chk("arst_k_addr", int'(bus.k_addr), 0);
    chk("arst_rd_en", int'(bus.mem_rd_en), 0);
    chk("arst_pc", int'(pass_count), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
